nv_clk_en_ctrl: RTL and testbench
=================================

// Module: nv_clk_en_ctrl
// PURPOSE
//  Idle-detect clock-enable controller that drives clk_en of the downstream power clock gate cell.
//  Watches unit busy and incoming request traffic. After a programmable run of idle cycles it
//  drops clk_en. It re-enables the clock on new demand and holds off requests for a fixed wake
//  latency. One instance per gated partition; sits in the free-running clock domain.
// PARAMETERS
//  IDLE_W       8   width of cfg_idle_cycles and of the idle counter
//  WAKE_CYCLES  2   cycles clk_en is high before req_ready reasserts (0 = no wake hold-off)
//  CNT_W        16  width of the gate-event statistics counter
// PORTS
//  clk              in   1       free-running clock (ungated)
//  reset_           in   1       async active-low reset
//  busy             in   1       gated partition has work in flight
//  req_valid        in   1       request pending for the gated partition
//  req_ready        out  1       partition clock stable; request may be accepted
//  cfg_idle_cycles  in   IDLE_W  consecutive idle cycles before gating (0 treated as 1)
//  cfg_gate_disable in   1       1 = never gate; clk_en held/forced high
//  cnt_clr          in   1       synchronous clear of gate_events
//  clk_en           out  1       registered enable to the clock gate
//  gated            out  1       status: state==OFF
//  gate_events      out  CNT_W   saturating count of entries into OFF
// BEHAVIOUR
//  Single clock; reset is asynchronous, active-low (reset_). All state is flop-based.
//  Reset: state=RUN, clk_en=1, req_ready=1, gated=0, gate_events=0, idle_cnt=0, wake_cnt=0.
//  - The clock runs out of reset so the gated domain sees its reset.
//  clk_en comes straight from a flop; no combinational path from any input. It is glitch-free.
//  idle = !busy && !req_valid. req_ready = (state==RUN || state==DRAIN). gated = (state==OFF).
//  FSM (next-state registered; clk_en = next-state != OFF, registered):
//   RUN : cfg_gate_disable                      -> RUN
//         idle && N<=1                          -> OFF
//         idle && N>1                           -> DRAIN, idle_cnt<=1
//         else                                  -> RUN
//   DRAIN: !idle || cfg_gate_disable            -> RUN, idle_cnt<=0
//          idle && idle_cnt+1 >= N              -> OFF
//          else                                 -> idle_cnt++ (saturating at all-ones)
//   OFF : req_valid || busy || cfg_gate_disable -> WAKE (WAKE_CYCLES=0: -> RUN), wake_cnt<=1
//         else                                  -> OFF
//   WAKE: wake_cnt==WAKE_CYCLES                 -> RUN; else wake_cnt++. Inputs ignored in WAKE.
//  N = cfg_idle_cycles (0 -> 1). Net effect: clk_en falls on the edge that ends the N-th
//  consecutive idle cycle. Comparison is >=, so a cfg change during DRAIN never wraps.
//  Wake latency: the req_valid cycle in OFF -> clk_en=1 at the next edge. req_ready=1
//  WAKE_CYCLES edges later. req_valid must be held until req_ready (valid/ready rule).
//  Simultaneous: busy/req_valid rising on the cycle DRAIN would enter OFF -> RUN wins; no gating.
//  gate_events: +1 on each transition into OFF. Saturates at all-ones.
//  - cnt_clr has priority over an increment in the same cycle (result 0).
//  Reset mid-operation (any state): async return to RUN with clk_en=1 immediately.
//  Sim-only checks (translate_off): clk_en never X after reset.
//  - busy/req_valid/cfg_gate_disable never X after reset.
//  - req_ready never 1 while state==OFF/WAKE.
// STRUCTURE
//  Shared package: state encoding constants (RUN=2'd0, DRAIN=2'd1, OFF=2'd2, WAKE=2'd3).
//  - Package also holds a CLKEN_RESET_VAL=1'b1 constant used by all power-gating controllers.
//  One sub-module: nv_sat_cnt (parameterised width, inc/clr, saturating).
//  - Used for both idle_cnt and gate_events.
//  Top level instantiates the FSM and feeds clk_en to the existing power clock gate.
// TESTING
//  1 Reset, busy=0, req_valid=0, N=3: clk_en=1 at release, falls after 3 idle edges.
//    - gated=1, gate_events=1.
//  2 In OFF, pulse req_valid (held) with WAKE_CYCLES=2: clk_en=1 next edge, req_ready=0 for 2
//    cycles, then req_ready=1 and state=RUN.
//  3 N=4, busy rises on idle cycle 4 (same edge as OFF entry): stays RUN, clk_en never drops.
//    - gate_events unchanged.
//  4 cfg_idle_cycles=0 and =1: both gate after exactly 1 idle cycle.
//    - cfg lowered 10->2 while idle_cnt=5: OFF next edge.
//  5 cfg_gate_disable=1 for 100 idle cycles: clk_en stays 1.
//    - Asserted while OFF: WAKE then RUN.
//  6 Assert reset_ low while OFF and while WAKE: clk_en=1, req_ready=1 asynchronously.
//    - gate_events=0. Also: saturate gate_events at 0xFFFF, then cnt_clr+increment -> 0.

Source files
------------

// File: rtl/nv_clk_en_ctrl_pkg.sv
// Shared definitions for the power-gating clock-enable controllers.
package nv_clk_en_ctrl_pkg;

    // Controller state encoding; the values are fixed so status decoders elsewhere agree.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        OFF   = 2'd2,
        WAKE  = 2'd3
    } clk_state_e;

    // Every power-gating controller leaves reset with its clock running so the
    // gated domain sees its own reset.
    localparam logic CLKEN_RESET_VAL = 1'b1;

endpackage

// File: rtl/nv_clk_en_ctrl_if.sv
// Traffic, configuration and status bundle between a partition and its clock-enable controller.
interface nv_clk_en_ctrl_if #(
    parameter int IDLE_W = 8,
    parameter int CNT_W  = 16
);
    logic              busy;
    logic              req_valid;
    logic              req_ready;
    logic [IDLE_W-1:0] cfg_idle_cycles;
    logic              cfg_gate_disable;
    logic              cnt_clr;
    logic              clk_en;
    logic              gated;
    logic [CNT_W-1:0]  gate_events;

    // Partition / configuration side.
    modport master (
        output busy, req_valid, cfg_idle_cycles, cfg_gate_disable, cnt_clr,
        input  req_ready, clk_en, gated, gate_events
    );

    // Controller side.
    modport slave (
        input  busy, req_valid, cfg_idle_cycles, cfg_gate_disable, cnt_clr,
        output req_ready, clk_en, gated, gate_events
    );
endinterface

// File: rtl/nv_sat_cnt.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module nv_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear beats increment; increment stops at all-ones.
    always_comb begin
        // NOTE: default first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/nv_clk_en_ctrl.sv
// Idle-detect clock-enable controller: gates a partition after a run of idle
// cycles and wakes it on new demand with a fixed hold-off before requests are accepted.
module nv_clk_en_ctrl
    import nv_clk_en_ctrl_pkg::*;
#(
    parameter int IDLE_W      = 8,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input logic             clk,
    input logic             reset_,
    nv_clk_en_ctrl_if.slave bus
);
    localparam int WAKE_W = (WAKE_CYCLES < 2) ? 1 : $clog2(WAKE_CYCLES + 1);

    clk_state_e        state_q, state_d;
    logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
    logic              clk_en_q, req_ready_q, gated_q;

    logic [IDLE_W-1:0] idle_cnt;
    logic              idle_inc, idle_clr;
    logic              gate_inc;
    logic              idle;
    logic [IDLE_W:0]   n_eff;
    logic [IDLE_W:0]   idle_cnt_p1;

    assign idle = !bus.busy && !bus.req_valid;

    // A threshold of 0 behaves as 1; one extra bit keeps idle_cnt+1 from wrapping.
    assign n_eff       = (bus.cfg_idle_cycles == '0) ? (IDLE_W+1)'(1) : {1'b0, bus.cfg_idle_cycles};
    assign idle_cnt_p1 = {1'b0, idle_cnt} + (IDLE_W+1)'(1);

    // Next-state and counter-control decode.
    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        idle_inc   = 1'b0;
        case (state_q)
            RUN: begin
                if (!bus.cfg_gate_disable && idle) begin
                    if (n_eff == (IDLE_W+1)'(1)) begin
                        state_d = OFF;
                    end else begin
                        state_d  = DRAIN;
                        idle_inc = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!idle || bus.cfg_gate_disable) begin
                    state_d = RUN;
                end else if (idle_cnt_p1 >= n_eff) begin
                    state_d = OFF;
                end else begin
                    idle_inc = 1'b1;
                end
            end
            OFF: begin
                if (bus.req_valid || bus.busy || bus.cfg_gate_disable) begin
                    if (WAKE_CYCLES == 0) begin
                        state_d = RUN;
                    end else begin
                        state_d    = WAKE;
                        wake_cnt_d = WAKE_W'(1);
                    end
                end
            end
            WAKE: begin
                if (wake_cnt_q == WAKE_W'(WAKE_CYCLES)) begin
                    state_d = RUN;
                end else begin
                    wake_cnt_d = wake_cnt_q + WAKE_W'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    // idle_cnt is zero outside DRAIN, so entering DRAIN with an increment lands on 1.
    assign idle_clr = (state_d != DRAIN);
    assign gate_inc = (state_d == OFF) && (state_q != OFF);

    // State and registered outputs; outputs are decoded from the next state so they
    // change on the same edge as the state and clk_en has no path from any input.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q     <= RUN;
            wake_cnt_q  <= '0;
            clk_en_q    <= CLKEN_RESET_VAL;
            req_ready_q <= 1'b1;
            gated_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wake_cnt_q  <= wake_cnt_d;
            clk_en_q    <= (state_d != OFF);
            req_ready_q <= (state_d == RUN) || (state_d == DRAIN);
            gated_q     <= (state_d == OFF);
        end
    end

    nv_sat_cnt #(.W(IDLE_W)) u_idle_cnt (
        .clk    (clk),
        .reset_ (reset_),
        .inc    (idle_inc),
        .clr    (idle_clr),
        .cnt    (idle_cnt)
    );

    nv_sat_cnt #(.W(CNT_W)) u_gate_events (
        .clk    (clk),
        .reset_ (reset_),
        .inc    (gate_inc),
        .clr    (bus.cnt_clr),
        .cnt    (bus.gate_events)
    );

    assign bus.clk_en    = clk_en_q;
    assign bus.req_ready = req_ready_q;
    assign bus.gated     = gated_q;

`ifndef SYNTHESIS
    a_clk_en_known: assert property (@(posedge clk) disable iff (!reset_) !$isunknown(clk_en_q));
    a_inputs_known: assert property (@(posedge clk) disable iff (!reset_)
        !$isunknown({bus.busy, bus.req_valid, bus.cfg_gate_disable}));
    a_no_ready_gated: assert property (@(posedge clk) disable iff (!reset_)
        !(req_ready_q && ((state_q == OFF) || (state_q == WAKE))));
`endif
endmodule

// File: tb/tb_nv_clk_en_ctrl.sv
// Directed, table-driven bench for the idle-detect clock-enable controller.
module tb_nv_clk_en_ctrl;
    logic clk;
    logic reset_;

    nv_clk_en_ctrl_if #(.IDLE_W(8), .CNT_W(16)) bus ();

    nv_clk_en_ctrl #(.IDLE_W(8), .WAKE_CYCLES(2), .CNT_W(16)) dut (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus)
    );

    // Stand-alone 16-bit counter for the saturation corner.
    logic        sat_inc, sat_clr;
    logic [15:0] sat_cnt;

    nv_sat_cnt #(.W(16)) u_sat (
        .clk    (clk),
        .reset_ (reset_),
        .inc    (sat_inc),
        .clr    (sat_clr),
        .cnt    (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic       busy;
        logic       req_valid;
        logic [7:0] cfg;
        logic       dis;
        logic       clr;
        logic       exp_clk_en;
        logic       exp_req_ready;
        logic       exp_gated;
        logic [15:0] exp_ge;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic b, input logic rv, input logic [7:0] cfg,
                       input logic dis, input logic clr, input logic ce, input logic rr,
                       input logic g, input logic [15:0] ge);
        vec_t v;
        v.name = name; v.busy = b; v.req_valid = rv; v.cfg = cfg; v.dis = dis; v.clr = clr;
        v.exp_clk_en = ce; v.exp_req_ready = rr; v.exp_gated = g; v.exp_ge = ge;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic b, input logic rv, input logic [7:0] cfg,
                         input logic dis, input logic clr);
        bus.busy = b;
        bus.req_valid = rv;
        bus.cfg_idle_cycles = cfg;
        bus.cfg_gate_disable = dis;
        bus.cnt_clr = clr;
    endtask

    task automatic expect4(input string name, input logic ce, input logic rr,
                           input logic g, input logic [15:0] ge);
        check({name, ".clk_en"},      32'(bus.clk_en),      32'(ce));
        check({name, ".req_ready"},   32'(bus.req_ready),   32'(rr));
        check({name, ".gated"},       32'(bus.gated),       32'(g));
        check({name, ".gate_events"}, 32'(bus.gate_events), 32'(ge));
    endtask

    // Apply one record's inputs, clock once, compare just after the edge.
    task automatic run_vec(input vec_t v);
        drive(v.busy, v.req_valid, v.cfg, v.dis, v.clr);
        @(posedge clk);
        #1;
        expect4(v.name, v.exp_clk_en, v.exp_req_ready, v.exp_gated, v.exp_ge);
    endtask

    initial begin
        //   name        busy rv cfg dis clr   clk_en rdy gated events
        add("t1_idle1",   0, 0, 8'd3,  0, 0,   1, 1, 0, 16'd0);
        add("t1_idle2",   0, 0, 8'd3,  0, 0,   1, 1, 0, 16'd0);
        add("t1_idle3",   0, 0, 8'd3,  0, 0,   0, 0, 1, 16'd1);
        add("t1_off",     0, 0, 8'd3,  0, 0,   0, 0, 1, 16'd1);
        add("t2_wake1",   0, 1, 8'd3,  0, 0,   1, 0, 0, 16'd1);
        add("t2_wake2",   0, 1, 8'd3,  0, 0,   1, 0, 0, 16'd1);
        add("t2_run",     0, 1, 8'd3,  0, 0,   1, 1, 0, 16'd1);
        add("t3_idle1",   0, 0, 8'd4,  0, 0,   1, 1, 0, 16'd1);
        add("t3_idle2",   0, 0, 8'd4,  0, 0,   1, 1, 0, 16'd1);
        add("t3_idle3",   0, 0, 8'd4,  0, 0,   1, 1, 0, 16'd1);
        add("t3_busy4",   1, 0, 8'd4,  0, 0,   1, 1, 0, 16'd1);
        add("t3_hold",    1, 0, 8'd4,  0, 0,   1, 1, 0, 16'd1);
        add("t4_n0",      0, 0, 8'd0,  0, 0,   0, 0, 1, 16'd2);
        add("t4_n0_w1",   1, 0, 8'd0,  0, 0,   1, 0, 0, 16'd2);
        add("t4_n0_w2",   1, 0, 8'd0,  0, 0,   1, 0, 0, 16'd2);
        add("t4_n0_run",  1, 0, 8'd0,  0, 0,   1, 1, 0, 16'd2);
        add("t4_n1",      0, 0, 8'd1,  0, 0,   0, 0, 1, 16'd3);
        add("t4_n1_w1",   1, 0, 8'd1,  0, 0,   1, 0, 0, 16'd3);
        add("t4_n1_w2",   1, 0, 8'd1,  0, 0,   1, 0, 0, 16'd3);
        add("t4_n1_run",  1, 0, 8'd1,  0, 0,   1, 1, 0, 16'd3);
        add("t4_d1",      0, 0, 8'd10, 0, 0,   1, 1, 0, 16'd3);
        add("t4_d2",      0, 0, 8'd10, 0, 0,   1, 1, 0, 16'd3);
        add("t4_d3",      0, 0, 8'd10, 0, 0,   1, 1, 0, 16'd3);
        add("t4_d4",      0, 0, 8'd10, 0, 0,   1, 1, 0, 16'd3);
        add("t4_d5",      0, 0, 8'd10, 0, 0,   1, 1, 0, 16'd3);
        add("t4_lower",   0, 0, 8'd2,  0, 0,   0, 0, 1, 16'd4);
        add("t5_dis_w1",  0, 0, 8'd2,  1, 0,   1, 0, 0, 16'd4);
        add("t5_dis_w2",  0, 0, 8'd2,  1, 0,   1, 0, 0, 16'd4);
        add("t5_dis_run", 0, 0, 8'd2,  1, 0,   1, 1, 0, 16'd4);

        reset_ = 1'b0;
        sat_inc = 1'b0;
        sat_clr = 1'b0;
        drive(0, 0, 8'd3, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        expect4("reset", 1, 1, 0, 16'd0);
        reset_ = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Gating disabled for 100 idle cycles: the clock must never drop.
        for (int i = 0; i < 100; i++) begin
            drive(0, 0, 8'd2, 1, 0);
            @(posedge clk);
            #1;
            check("t5_dis_idle.clk_en", 32'(bus.clk_en), 32'd1);
        end

        // Re-enable gating; clear lands on the same edge as the OFF entry increment.
        drive(0, 0, 8'd2, 0, 0);
        @(posedge clk); #1;
        expect4("t6_drain", 1, 1, 0, 16'd4);
        drive(0, 0, 8'd2, 0, 1);
        @(posedge clk); #1;
        expect4("t6_clr_inc", 0, 0, 1, 16'd0);

        // Asynchronous reset while OFF: outputs recover with no clock edge.
        drive(0, 0, 8'd1, 0, 0);
        #2 reset_ = 1'b0;
        #1;
        expect4("t6_rst_off", 1, 1, 0, 16'd0);
        @(posedge clk); #1;
        reset_ = 1'b1;

        // Re-enter OFF, start a wake, then reset in the middle of WAKE.
        @(posedge clk); #1;
        expect4("t6_off_again", 0, 0, 1, 16'd1);
        drive(0, 1, 8'd1, 0, 0);
        @(posedge clk); #1;
        expect4("t6_in_wake", 1, 0, 0, 16'd1);
        #2 reset_ = 1'b0;
        #1;
        expect4("t6_rst_wake", 1, 1, 0, 16'd0);
        drive(1, 0, 8'd1, 0, 0);
        @(posedge clk); #1;
        reset_ = 1'b1;
        @(posedge clk); #1;
        expect4("t6_post_rst", 1, 1, 0, 16'd0);

        // 16-bit saturation: 65535 increments reach all-ones, then stick.
        sat_inc = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        check("sat_full", 32'(sat_cnt), 32'h0000_ffff);
        @(posedge clk); #1;
        check("sat_stick", 32'(sat_cnt), 32'h0000_ffff);
        sat_clr = 1'b1;
        @(posedge clk); #1;
        check("sat_clr_inc", 32'(sat_cnt), 32'h0000_0000);
        sat_clr = 1'b0;
        sat_inc = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
